// File: rtl/fir_host_ctrl.sv
// Host-side sequencer for the FIR accelerator: programs taps, length and ap_start over
// AXI-Lite, streams X/Y between the user ports and the FIR, then polls ap_done.
module fir_host_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tap_Num     = 11,
  parameter int Poll_Max    = 1023
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cmd_start,
  input  logic [pDATA_WIDTH-1:0] cmd_len,
  input  logic                   tap_ld_en,
  input  logic [3:0]             tap_ld_idx,
  input  logic [pDATA_WIDTH-1:0] tap_ld_data,
  input  logic                   x_valid,
  input  logic [pDATA_WIDTH-1:0] x_data,
  output logic                   x_ready,
  output logic                   y_valid,
  output logic [pDATA_WIDTH-1:0] y_data,
  input  logic                   y_ready,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast,
  output logic                   sm_tready,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             state_dbg
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1; once raised,
  // a valid holds its payload stable until that edge and never depends on the same-cycle ready.
  typedef enum logic [2:0] {IDLE, WR_TAP, WR_LEN, WR_START, STREAM, POLL, FIN} state_t;
  localparam int PW = $clog2(Poll_Max + 1);
  localparam int TW = $clog2(Tap_Num);

  state_t                 state, state_nxt;
  logic [pDATA_WIDTH-1:0] taps [Tap_Num];
  logic [pDATA_WIDTH-1:0] len_q, tx_cnt, rx_cnt, beat_data;
  logic [pADDR_WIDTH-1:0] beat_addr;
  logic [TW-1:0]          tap_idx;
  logic [PW-1:0]          poll_cnt;
  logic aw_done, w_done, accept, in_wr, in_beat, beat_issue, beat_done, in_stream;
  logic tx_more, rx_more, tx_fire, rx_fire, ar_fire, r_fire, poll_hit, poll_last, rd_first, rd_again;
  logic unused_rdata;

  assign accept     = cmd_start && (state == IDLE || state == FIN);
  assign in_wr      = state inside {WR_TAP, WR_LEN, WR_START};
  assign in_beat    = awvalid | wvalid | aw_done | w_done;
  assign beat_issue = in_wr & ~in_beat;
  assign beat_done  = in_wr & in_beat & (aw_done | (awvalid & awready)) & (w_done | (wvalid & wready));

  assign in_stream = (state == STREAM);
  assign tx_more   = tx_cnt < len_q;
  assign rx_more   = rx_cnt < len_q;
  assign ss_tvalid = in_stream & x_valid & tx_more;
  assign x_ready   = in_stream & ss_tready & tx_more;
  assign ss_tdata  = in_stream ? x_data : '0;
  assign ss_tlast  = in_stream & tx_more & (tx_cnt == len_q - pDATA_WIDTH'(1));
  assign y_valid   = in_stream & sm_tvalid & rx_more;
  assign sm_tready = in_stream & y_ready & rx_more;
  assign y_data    = in_stream ? sm_tdata : '0;
  assign tx_fire   = ss_tvalid & ss_tready;
  assign rx_fire   = sm_tvalid & sm_tready;

  assign ar_fire   = arvalid & arready;
  assign r_fire    = rvalid & rready;
  assign poll_hit  = r_fire & rdata[1];
  assign poll_last = r_fire & ~rdata[1] & (poll_cnt == PW'(Poll_Max - 1));
  assign rd_first  = (state == POLL) & (poll_cnt == '0) & ~arvalid & ~rready;
  assign rd_again  = r_fire & ~rdata[1] & ~poll_last;
  assign araddr    = '0;
  assign unused_rdata = ^{rdata[pDATA_WIDTH-1:2], rdata[0]};

  assign busy      = !(state == IDLE || state == FIN);
  assign done      = (state == FIN);
  assign state_dbg = state;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (accept) state_nxt = (cmd_len == '0) ? FIN : WR_TAP;
        else        state_nxt = IDLE;
      end
      WR_TAP:   if (beat_done && tap_idx == TW'(Tap_Num - 1)) state_nxt = WR_LEN;
      WR_LEN:   if (beat_done) state_nxt = WR_START;
      WR_START: if (beat_done) state_nxt = STREAM;
      STREAM:   if (tx_cnt == len_q && rx_cnt == len_q) state_nxt = POLL;
      POLL:     if (poll_hit || poll_last) state_nxt = FIN;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    beat_addr = '0;
    beat_data = '0;
    case (state)
      WR_TAP: begin
        beat_addr = pADDR_WIDTH'(32'h20 + 32'(tap_idx) * 32'd4);
        beat_data = taps[tap_idx];
      end
      WR_LEN: begin
        beat_addr = pADDR_WIDTH'(32'h10);
        beat_data = len_q;
      end
      WR_START: beat_data = pDATA_WIDTH'(1);
      default: ;
    endcase
  end

  // AW and W retire independently; the beat ends once both have been accepted.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      tap_idx <= '0;
    end else begin
      awvalid <= beat_issue | (awvalid & ~awready);
      wvalid  <= beat_issue | (wvalid & ~wready);
      aw_done <= ~beat_done & (aw_done | (awvalid & awready));
      w_done  <= ~beat_done & (w_done | (wvalid & wready));
      if (beat_issue) begin
        awaddr <= beat_addr;
        wdata  <= beat_data;
      end
      if (accept) tap_idx <= '0;
      else if (beat_done && state == WR_TAP)
        tap_idx <= (tap_idx == TW'(Tap_Num - 1)) ? '0 : tap_idx + TW'(1);
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      poll_cnt <= '0;
    end else begin
      arvalid <= rd_first | rd_again | (arvalid & ~arready);
      rready  <= ar_fire | (rready & ~rvalid);
      if (accept)      poll_cnt <= '0;
      else if (r_fire) poll_cnt <= poll_cnt + PW'(1);
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      len_q  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      err    <= 1'b0;
      for (int i = 0; i < Tap_Num; i++) taps[i] <= '0;
    end else begin
      if (accept) begin
        len_q  <= cmd_len;
        tx_cnt <= '0;
        rx_cnt <= '0;
        err    <= (cmd_len == '0);
      end else begin
        if (tx_fire) tx_cnt <= tx_cnt + pDATA_WIDTH'(1);
        if (rx_fire) rx_cnt <= rx_cnt + pDATA_WIDTH'(1);
        // The FIR must flag exactly the final Y beat with tlast.
        if ((rx_fire && (sm_tlast != (rx_cnt == len_q - pDATA_WIDTH'(1)))) || poll_last) err <= 1'b1;
      end
      if (tap_ld_en && !busy && 32'(tap_ld_idx) < Tap_Num) taps[tap_ld_idx] <= tap_ld_data;
    end
  end
endmodule

// File: tb/tb_fir_host_ctrl.sv
// Bench for fir_host_ctrl: AXI-Lite slave, FIR stream model and scoreboards for the
// register writes and the Y samples, driven by a directed sequence of runs.
module tb_fir_host_ctrl;
  localparam int AW = 12, DW = 32, NT = 11, PMAX = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_start = 0, tap_ld_en = 0;
  logic [DW-1:0] cmd_len = '0, tap_ld_data = '0;
  logic [3:0] tap_ld_idx = '0;
  logic x_valid = 0, x_ready, y_valid, y_ready = 1;
  logic [DW-1:0] x_data = '0, y_data;
  logic awvalid, awready = 0, wvalid, wready = 0, arvalid, arready = 0, rvalid = 0, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata = '0;
  logic ss_tvalid, ss_tlast, ss_tready = 0, sm_tvalid = 0, sm_tlast = 0, sm_tready;
  logic [DW-1:0] ss_tdata, sm_tdata = '0;
  logic busy, done, err;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  fir_host_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tap_Num(NT), .Poll_Max(PMAX)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .tap_ld_en(tap_ld_en), .tap_ld_idx(tap_ld_idx), .tap_ld_data(tap_ld_data),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  int total = 0, bad = 0;
  logic [DW-1:0]    exp_q[$];     // expected Y samples
  logic [AW+DW-1:0] exp_wr_q[$];  // expected {addr,data} register writes
  logic [AW-1:0]    aw_q[$];
  logic [DW-1:0]    wd_q[$], fir_q[$];
  int tap_tbl [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  int reg_tap [NT], x_hist [NT], m_hist [NT];
  int reg_len, n_x, n_ss, n_y_fir, n_y, n_aw, n_w, n_reads, aw_only, x_total;
  int aw_stall, bad_last;
  bit fir_run, ap_done_flag, r_pend, err_chk, w_rand, x_rand, y_toggle, ap_never;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete(); exp_wr_q.delete(); aw_q.delete(); wd_q.delete(); fir_q.delete();
    for (int k = 0; k < NT; k++) begin reg_tap[k] = 0; x_hist[k] = 0; m_hist[k] = 0; end
    reg_len = 0; n_x = 0; n_ss = 0; n_y_fir = 0; n_y = 0; n_aw = 0; n_w = 0;
    n_reads = 0; aw_only = 0; x_total = 0;
    fir_run = 0; ap_done_flag = 0; r_pend = 0; err_chk = 0;
  endtask

  task automatic knobs_clear();
    aw_stall = 0; bad_last = -1; w_rand = 0; x_rand = 0; y_toggle = 0; ap_never = 0;
  endtask

  // Bus/stream models: drive on the falling edge, observe handshakes 1 ns later.
  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d, e;
    logic [AW+DW-1:0] ew;
    int acc;
    forever begin
      @(negedge clk);
      if (err_chk) begin chk("err_at_bad_tlast", err, 1); err_chk = 0; end
      if (awvalid && aw_stall > 0) begin awready = 0; aw_stall--; end
      else awready = 1;
      wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      arready = 1;
      rvalid  = r_pend;
      rdata   = (r_pend && ap_done_flag) ? 32'h2 : 32'h0;
      ss_tready = ($urandom_range(0, 3) != 0);
      if (fir_q.size() > 0) begin
        sm_tvalid = 1; sm_tdata = fir_q[0];
        sm_tlast  = (n_y_fir == reg_len - 1) || (n_y_fir == bad_last);
      end else begin
        sm_tvalid = 0; sm_tdata = '0; sm_tlast = 0;
      end
      x_valid = (n_x < x_total) && (!x_rand || $urandom_range(0, 1) == 1);
      x_data  = n_x;
      y_ready = y_toggle ? ~y_ready : 1'b1;
      #1;
      if (awvalid && awready) begin aw_q.push_back(awaddr); n_aw++; end
      if (wvalid && wready) begin wd_q.push_back(wdata); n_w++; end
      if (awvalid && !wvalid) aw_only++;
      while (aw_q.size() > 0 && wd_q.size() > 0) begin
        a = aw_q.pop_front(); d = wd_q.pop_front();
        if (exp_wr_q.size() > 0) ew = exp_wr_q.pop_front(); else ew = '1;
        chk("axil_wr_addr", 32'(a), 32'(ew[AW+DW-1:DW]));
        chk("axil_wr_data", d, ew[DW-1:0]);
        if (a >= 12'h20 && a < 12'(32'h20 + 4 * NT)) reg_tap[(a - 12'h20) / 4] = d;
        if (a == 12'h10) reg_len = d;
        if (a == 12'h00 && d[0]) fir_run = 1;
      end
      if (rvalid && rready) r_pend = 0;
      if (arvalid && arready) begin n_reads++; chk("araddr", 32'(araddr), 0); r_pend = 1; end
      if (x_valid && x_ready) begin
        for (int k = NT - 1; k > 0; k--) x_hist[k] = x_hist[k-1];
        x_hist[0] = x_data; acc = 0;
        for (int k = 0; k < NT; k++) acc += tap_tbl[k] * x_hist[k];
        exp_q.push_back(acc);
        n_x++;
      end
      if (ss_tvalid && ss_tready) begin
        chk("ss_tlast", ss_tlast, (n_ss == reg_len - 1));
        for (int k = NT - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = ss_tdata; acc = 0;
        for (int k = 0; k < NT; k++) acc += reg_tap[k] * m_hist[k];
        fir_q.push_back(acc);
        n_ss++;
      end
      if (sm_tvalid && sm_tready) begin
        void'(fir_q.pop_front());
        if (n_y_fir == bad_last) err_chk = 1;
        n_y_fir++;
      end
      if (y_valid && y_ready) begin
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 32'hdead_beef;
        chk("y_data", y_data, e);
        n_y++;
      end
      if (fir_run && !ap_never && n_y_fir == reg_len) ap_done_flag = 1;
    end
  end

  task automatic load_taps();
    for (int i = 0; i <= NT; i++) begin
      @(negedge clk);
      tap_ld_en = 1; tap_ld_idx = 4'(i);
      tap_ld_data = (i < NT) ? tap_tbl[i] : 32'h77;
    end
    @(negedge clk); tap_ld_en = 0;
  endtask

  task automatic start_run(input int len);
    @(negedge clk); #3;
    model_clear();
    if (len != 0) begin
      for (int i = 0; i < NT; i++) exp_wr_q.push_back({12'(32'h20 + 4 * i), 32'(tap_tbl[i])});
      exp_wr_q.push_back({12'h10, 32'(len)});
      exp_wr_q.push_back({12'h00, 32'h1});
    end
    x_total = len;
    @(negedge clk); cmd_len = len; cmd_start = 1;
    @(negedge clk); cmd_start = 0;
    chk("busy_after_start", busy, (len != 0));
  endtask

  task automatic wait_x(input int n, input string tag);
    int cyc = 0;
    while (n_x < n && cyc < 5000) begin @(negedge clk); cyc++; end
    chk({tag, "_x_reached"}, (n_x >= n), 1);
  endtask

  task automatic wait_done(input int budget, input logic exp_err, input string tag);
    int cyc = 0;
    bit seen = done;
    while (!seen && cyc < budget) begin
      @(negedge clk); cyc++;
      if (done) seen = 1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_err"}, err, exp_err);
      @(negedge clk);
      chk({tag, "_done_pulse_1cyc"}, done, 0);
    end
  endtask

  task automatic end_counts(input int len, input string tag);
    chk({tag, "_y_count"}, n_y, len);
    chk({tag, "_ss_count"}, n_ss, len);
    chk({tag, "_y_left"}, exp_q.size(), 0);
    chk({tag, "_wr_left"}, exp_wr_q.size(), 0);
    chk({tag, "_aw_beats"}, n_aw, NT + 2);
    chk({tag, "_w_beats"}, n_w, NT + 2);
  endtask

  initial begin
    knobs_clear();
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_ctrl_outs", {awvalid, wvalid, arvalid, rready, ss_tvalid, ss_tlast, x_ready,
                          y_valid, sm_tready, busy, done, err}, 0);
    chk("rst_awaddr", 32'(awaddr), 0);
    chk("rst_wdata", wdata, 0);
    rst_n = 1;
    load_taps();

    // Nominal run with AW held off for 3 cycles on the first beat, plus ignored requests.
    aw_stall = 3;
    start_run(600);
    wait_x(50, "run600");
    @(negedge clk);
    cmd_len = 7; cmd_start = 1; tap_ld_en = 1; tap_ld_idx = 0; tap_ld_data = 999;
    @(negedge clk);
    cmd_start = 0; tap_ld_en = 0;
    chk("run600_busy_kept", busy, 1);
    wait_done(20000, 0, "run600");
    end_counts(600, "run600");
    chk("run600_aw_only_cycles", aw_only, 3);
    chk("run600_reads", n_reads, 1);
    knobs_clear();

    // Backpressured Y, bursty X, random wready.
    y_toggle = 1; x_rand = 1; w_rand = 1;
    start_run(50);
    wait_done(20000, 0, "run50");
    end_counts(50, "run50");
    knobs_clear();

    // FIR flags tlast early on Y#5.
    bad_last = 5;
    start_run(10);
    wait_done(20000, 1, "badlast");
    end_counts(10, "badlast");
    knobs_clear();

    // ap_done never rises: Poll_Max reads then error.
    ap_never = 1;
    start_run(5);
    wait_done(20000, 1, "polltmo");
    chk("polltmo_reads", n_reads, PMAX);
    chk("polltmo_y_count", n_y, 5);
    knobs_clear();

    // Zero length: error and done without bus activity.
    start_run(0);
    wait_done(5, 1, "len0");
    chk("len0_aw", n_aw, 0);
    chk("len0_ar", n_reads, 0);

    // Reset in the middle of streaming, then a clean rerun.
    start_run(600);
    wait_x(100, "rstmid");
    rst_n = 0;
    #1;
    chk("rstmid_outs", {awvalid, wvalid, arvalid, rready, ss_tvalid, ss_tlast, x_ready,
                        y_valid, sm_tready, busy, done, err}, 0);
    repeat (2) @(negedge clk);
    model_clear();
    rst_n = 1;
    load_taps();
    start_run(20);
    wait_done(20000, 0, "rerun");
    end_counts(20, "rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
